// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared MMU types for the TLB/PTW interface and the PTW arbiter
package mmu_pkg;

    localparam int PTW_ARB_MAX_REQ = 8;
    localparam int VPN_W           = 27;
    localparam int PTE_W           = 64;
    localparam int ASID_W          = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } ptw_arb_state_t;

    // TLB -> PTW walk request
    typedef struct packed {
        logic              valid;
        logic [VPN_W-1:0]  vpn;
        logic [ASID_W-1:0] asid;
        logic              store;
        logic              fetch;
    } tlb_ptw_comm_t;

    typedef struct packed {
        logic             valid;
        logic             error;
        logic [PTE_W-1:0] pte;
    } ptw_resp_t;

    typedef struct packed {
        logic [1:0]        prv;
        logic              sum;
        logic              mxr;
        logic [ASID_W-1:0] asid;
    } ptw_status_t;

    // PTW -> TLB ready/response/status
    typedef struct packed {
        logic        ptw_ready;
        ptw_resp_t   resp;
        ptw_status_t ptw_status;
        logic        invalidate_tlb;
    } ptw_tlb_comm_t;

    // Index width for an n-entry vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ptw_rr_picker.sv
// rtl/ptw_rr_picker.sv - combinational round-robin / fixed-priority winner picker
//
// Picks one set bit of pend_i. PRIO_MODE=0 searches upward from ptr_i,
// wrapping modulo N_REQ; PRIO_MODE=1 picks the lowest set index and ignores ptr_i.
// Ports:
//   pend_i    in   N_REQ   pending request vector
//   ptr_i     in   IDX_W   round-robin start index
//   winner_o  out  IDX_W   selected index (0 when nothing pending)
//   any_o     out  1       at least one bit of pend_i is set
module ptw_rr_picker
    import mmu_pkg::*;
#(
    parameter int   N_REQ     = 2,
    parameter int   PRIO_MODE = 0,
    localparam int  IDX_W     = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] pend_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_o
);

    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (PRIO_MODE != 0) ? k : ((int'(ptr_i) + k) % N_REQ);
            if (!any_o && pend_i[idx]) begin
                any_o    = 1'b1;
                winner_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ptw_arb_rr.sv
// rtl/ptw_arb_rr.sv - N-channel TLB-to-PTW request arbiter with per-channel request buffers
//
// Each channel owns a one-entry buffer; the arbiter grants one buffered request
// at a time to the page-table walker, holds it until the walker responds and
// routes the response back to the granted channel only. ptw_status and
// invalidate_tlb are broadcast. Optional feature macro: PTW_ARB_PERF_EN adds
// saturating per-channel grant counters and a wait-cycle counter.
// Ports:
//   clk_i             in   1                       clock
//   rst_i             in   1                       synchronous active-high reset
//   req_comm_i        in   N_REQ x tlb_ptw_comm_t  per-channel request
//   req_comm_o        out  N_REQ x ptw_tlb_comm_t  per-channel ready/resp/status
//   flush_i           in   1                       drop buffered, not yet issued requests
//   ptw_comm_i        in   ptw_tlb_comm_t          from the walker
//   ptw_comm_o        out  tlb_ptw_comm_t          to the walker
//   perf_grant_cnt_o  out  N_REQ x CNT_W           grants per channel (PTW_ARB_PERF_EN)
//   perf_wait_cnt_o   out  CNT_W                   cycles with an ungranted pending channel (PTW_ARB_PERF_EN)
module ptw_arb_rr
    import mmu_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  tlb_ptw_comm_t req_comm_i [N_REQ],
    output ptw_tlb_comm_t req_comm_o [N_REQ],
    input  logic          flush_i,
    input  ptw_tlb_comm_t ptw_comm_i,
    output tlb_ptw_comm_t ptw_comm_o
`ifdef PTW_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_grant_cnt_o [N_REQ],
    output logic [CNT_W-1:0] perf_wait_cnt_o
`endif
);

    localparam int IDX_W = idx_width(N_REQ);

    ptw_arb_state_t   state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    tlb_ptw_comm_t    buf_q [N_REQ];
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] winner;
    logic             any_pend;
    logic             resp_fire;
    logic             grant_fire;
    logic [N_REQ-1:0] ready;
    logic [N_REQ-1:0] capture;
    logic [N_REQ-1:0] grant_mask;

    ptw_rr_picker #(
        .N_REQ     (N_REQ),
        .PRIO_MODE (PRIO_MODE)
    ) u_picker (
        .pend_i   (pend_q),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_pend)
    );

    // A channel stays not-ready from capture until its response is delivered.
    always_comb begin
        ready      = '0;
        capture    = '0;
        grant_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ready[i]      = !pend_q[i] && !flush_i;
            capture[i]    = req_comm_i[i].valid && ready[i];
            grant_mask[i] = (state_q != IDLE) && (grant_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        resp_fire  = 1'b0;
        grant_fire = 1'b0;
        ptw_comm_o = '0;
        case (state_q)
            IDLE: begin
                // A flush in IDLE drops every buffered request, so nothing is granted.
                if (any_pend && !flush_i) begin
                    grant_fire = 1'b1;
                    grant_d    = winner;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                ptw_comm_o = buf_q[grant_q];
                if (ptw_comm_i.ptw_ready) begin
                    if (ptw_comm_i.resp.valid) begin
                        resp_fire = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                ptw_comm_o = buf_q[grant_q];
                if (ptw_comm_i.resp.valid) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (resp_fire) begin
            rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    // Flush keeps only the in-flight channel; capture never coincides with a
    // flush or with the same channel's response because ready is low then.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = pend_q & grant_mask;
        end
        if (resp_fire) begin
            pend_d[grant_q] = 1'b0;
        end
        pend_d = pend_d | capture;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < N_REQ; i++) begin
                if (capture[i]) begin
                    buf_q[i] <= req_comm_i[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_comm_o[i]                = '0;
            req_comm_o[i].ptw_ready      = ready[i];
            req_comm_o[i].ptw_status     = ptw_comm_i.ptw_status;
            req_comm_o[i].invalidate_tlb = ptw_comm_i.invalidate_tlb;
            if (resp_fire && (grant_q == IDX_W'(i))) begin
                req_comm_o[i].resp = ptw_comm_i.resp;
            end
        end
    end

`ifdef PTW_ARB_PERF_EN
    logic [CNT_W-1:0] grant_cnt_q [N_REQ];
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_fire && (winner == IDX_W'(i)) && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
                end
            end
            if (((pend_q & ~grant_mask) != '0) && (wait_cnt_q != '1)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        perf_wait_cnt_o = wait_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            perf_grant_cnt_o[i] = grant_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_ptw_arb_rr.sv
// tb/tb_ptw_arb_rr.sv - directed table-driven bench for ptw_arb_rr
module tb_ptw_arb_rr;
    import mmu_pkg::*;

    localparam int               NQ       = 4;
    localparam logic [VPN_W-1:0] VPN_BASE = 27'h100;
    localparam logic [PTE_W-1:0] PTE_VAL  = 64'hDEAD_BEEF_0000_1234;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush;
    tlb_ptw_comm_t req_i [NQ];
    ptw_tlb_comm_t ptw_i;
    ptw_tlb_comm_t rr_o [NQ];
    ptw_tlb_comm_t fp_o [NQ];
    tlb_ptw_comm_t rr_ptw_o;
    tlb_ptw_comm_t fp_ptw_o;
`ifdef PTW_ARB_PERF_EN
    logic [3:0] rr_gcnt [NQ];
    logic [3:0] rr_wcnt;
    logic [3:0] fp_gcnt [NQ];
    logic [3:0] fp_wcnt;
`endif

    int errors = 0;
    int checks = 0;
    bit sel    = 1'b0;

    always #5 clk = ~clk;

    ptw_arb_rr #(.N_REQ(NQ), .PRIO_MODE(0), .CNT_W(4)) u_rr (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_comm_i (req_i),
        .req_comm_o (rr_o),
        .flush_i    (flush),
        .ptw_comm_i (ptw_i),
        .ptw_comm_o (rr_ptw_o)
`ifdef PTW_ARB_PERF_EN
        ,
        .perf_grant_cnt_o (rr_gcnt),
        .perf_wait_cnt_o  (rr_wcnt)
`endif
    );

    ptw_arb_rr #(.N_REQ(NQ), .PRIO_MODE(1), .CNT_W(4)) u_fp (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_comm_i (req_i),
        .req_comm_o (fp_o),
        .flush_i    (flush),
        .ptw_comm_i (ptw_i),
        .ptw_comm_o (fp_ptw_o)
`ifdef PTW_ARB_PERF_EN
        ,
        .perf_grant_cnt_o (fp_gcnt),
        .perf_wait_cnt_o  (fp_wcnt)
`endif
    );

    typedef struct {
        logic [3:0] rv;
        logic       pr;
        logic       rs;
        logic       fl;
        logic [3:0] rdy;
        logic       ov;
        int         och;
        logic [3:0] rsp;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [3:0] rdy_mask();
        logic [3:0] m;
        for (int i = 0; i < NQ; i++) m[i] = sel ? fp_o[i].ptw_ready : rr_o[i].ptw_ready;
        return m;
    endfunction

    function automatic logic [3:0] rsp_mask();
        logic [3:0] m;
        for (int i = 0; i < NQ; i++) m[i] = sel ? fp_o[i].resp.valid : rr_o[i].resp.valid;
        return m;
    endfunction

    function automatic tlb_ptw_comm_t pout();
        return sel ? fp_ptw_o : rr_ptw_o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic pr, input logic rs, input logic fl);
        for (int i = 0; i < NQ; i++) begin
            req_i[i].valid = rv[i];
            req_i[i].vpn   = VPN_BASE + VPN_W'(i);
            req_i[i].asid  = 16'h5;
            req_i[i].store = 1'b0;
            req_i[i].fetch = (i == 1);
        end
        ptw_i.ptw_ready  = pr;
        ptw_i.resp.valid = rs;
        flush            = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'h0, 1'b1, 1'b0, 1'b0);
        ptw_i.invalidate_tlb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Waits (bounded) for a walk to appear on the walker port and checks its channel.
    task automatic wait_grant(input string name, input int exp_ch);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            next_cycle();
            #2;
            if (pout().valid) found = 1'b1;
        end
        if (!found) check({name, "_timeout"}, 64'd0, 64'd1);
        else        check(name, 64'(pout().vpn), 64'(VPN_BASE + VPN_W'(exp_ch)));
    endtask

    task automatic respond(input string name, input logic [3:0] exp_rsp);
        ptw_i.resp.valid = 1'b1;
        #1;
        check(name, 64'(rsp_mask()), 64'(exp_rsp));
        next_cycle();
        ptw_i.resp.valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic pr, input logic rs,
                                input logic [3:0] rdy, input logic ov, input int och,
                                input logic [3:0] rsp);
        vec_t v;
        v.rv = rv; v.pr = pr; v.rs = rs; v.fl = 1'b0;
        v.rdy = rdy; v.ov = ov; v.och = och; v.rsp = rsp;
        return v;
    endfunction

    initial begin
        ptw_i            = '0;
        ptw_i.resp.pte   = PTE_VAL;
        ptw_i.ptw_status = '{prv: 2'd1, sum: 1'b0, mxr: 1'b1, asid: 16'h5};
        drive(4'h0, 1'b1, 1'b0, 1'b0);

        // Cycle table: two-channel collision, zero-latency walk, walker stall, stray response.
        tbl[0]  = mk(4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 0, 4'h0);
        tbl[1]  = mk(4'h3, 1'b0, 1'b0, 4'hF, 1'b0, 0, 4'h0);
        tbl[2]  = mk(4'h0, 1'b1, 1'b0, 4'hC, 1'b0, 0, 4'h0);
        tbl[3]  = mk(4'h0, 1'b1, 1'b0, 4'hC, 1'b1, 0, 4'h0);
        tbl[4]  = mk(4'h0, 1'b0, 1'b0, 4'hC, 1'b1, 0, 4'h0);
        tbl[5]  = mk(4'h0, 1'b0, 1'b0, 4'hC, 1'b1, 0, 4'h0);
        tbl[6]  = mk(4'h0, 1'b0, 1'b0, 4'hC, 1'b1, 0, 4'h0);
        tbl[7]  = mk(4'h0, 1'b0, 1'b0, 4'hC, 1'b1, 0, 4'h0);
        tbl[8]  = mk(4'h0, 1'b0, 1'b1, 4'hC, 1'b1, 0, 4'h1);
        tbl[9]  = mk(4'h0, 1'b1, 1'b0, 4'hD, 1'b0, 0, 4'h0);
        tbl[10] = mk(4'h0, 1'b1, 1'b1, 4'hD, 1'b1, 1, 4'h2);
        tbl[11] = mk(4'h0, 1'b1, 1'b0, 4'hF, 1'b0, 0, 4'h0);
        tbl[12] = mk(4'h4, 1'b0, 1'b0, 4'hF, 1'b0, 0, 4'h0);
        tbl[13] = mk(4'h0, 1'b0, 1'b0, 4'hB, 1'b0, 0, 4'h0);
        tbl[14] = mk(4'h0, 1'b0, 1'b0, 4'hB, 1'b1, 2, 4'h0);
        tbl[15] = mk(4'h0, 1'b0, 1'b0, 4'hB, 1'b1, 2, 4'h0);
        tbl[16] = mk(4'h0, 1'b0, 1'b0, 4'hB, 1'b1, 2, 4'h0);
        tbl[17] = mk(4'h0, 1'b1, 1'b0, 4'hB, 1'b1, 2, 4'h0);
        tbl[18] = mk(4'h0, 1'b0, 1'b1, 4'hB, 1'b1, 2, 4'h4);
        tbl[19] = mk(4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 0, 4'h0);

        do_reset();
        sel = 1'b0;
        for (int r = 0; r < 20; r++) begin
            next_cycle();
            drive(tbl[r].rv, tbl[r].pr, tbl[r].rs, tbl[r].fl);
            #2;
            check($sformatf("row%0d_ready", r), 64'(rdy_mask()), 64'(tbl[r].rdy));
            check($sformatf("row%0d_ptw_o", r), 64'({pout().valid, pout().vpn}),
                  tbl[r].ov ? 64'({1'b1, VPN_BASE + VPN_W'(tbl[r].och)}) : 64'd0);
            check($sformatf("row%0d_resp", r), 64'(rsp_mask()), 64'(tbl[r].rsp));
        end

        // Round-robin fairness with all channels re-requesting.
        do_reset();
        sel = 1'b0;
        drive(4'hF, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            wait_grant($sformatf("rr_grant%0d", k), k % 4);
            respond($sformatf("rr_resp%0d", k), 4'(1 << (k % 4)));
        end

        // Fixed priority: ch1 after ch3, then ch0 beats ch2.
        do_reset();
        sel = 1'b1;
        next_cycle(); drive(4'h8, 1'b1, 1'b0, 1'b0);
        next_cycle(); drive(4'h0, 1'b1, 1'b0, 1'b0);
        wait_grant("fp_grant_ch3", 3);
        next_cycle(); drive(4'h2, 1'b1, 1'b0, 1'b0);
        next_cycle(); drive(4'h0, 1'b1, 1'b0, 1'b0);
        #1;
        respond("fp_resp_ch3", 4'h8);
        wait_grant("fp_grant_ch1", 1);
        next_cycle(); drive(4'h4, 1'b1, 1'b0, 1'b0);
        next_cycle(); drive(4'h1, 1'b1, 1'b0, 1'b0);
        next_cycle(); drive(4'h0, 1'b1, 1'b0, 1'b0);
        #1;
        respond("fp_resp_ch1", 4'h2);
        wait_grant("fp_grant_ch0", 0);
        respond("fp_resp_ch0", 4'h1);
        wait_grant("fp_grant_ch2", 2);
        respond("fp_resp_ch2", 4'h4);

        // Flush during a walk drops ch1 but completes ch0.
        do_reset();
        sel = 1'b0;
        next_cycle(); drive(4'h1, 1'b1, 1'b0, 1'b0);
        next_cycle(); drive(4'h0, 1'b1, 1'b0, 1'b0);
        wait_grant("flush_grant_ch0", 0);
        next_cycle(); drive(4'h2, 1'b0, 1'b0, 1'b0);
        next_cycle(); drive(4'h0, 1'b0, 1'b0, 1'b1);
        #2;
        check("flush_ready_low", 64'(rdy_mask()), 64'h0);
        next_cycle(); drive(4'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("flush_drop_ch1", 64'(rdy_mask()), 64'hE);
        ptw_i.invalidate_tlb = 1'b1;
        ptw_i.resp.valid     = 1'b1;
        #1;
        check("flush_resp_mask", 64'(rsp_mask()), 64'h1);
        check("flush_resp_pte", rr_o[0].resp.pte, PTE_VAL);
        check("flush_inval_bcast", 64'(rr_o[3].invalidate_tlb), 64'd1);
        next_cycle();
        ptw_i.resp.valid     = 1'b0;
        ptw_i.invalidate_tlb = 1'b0;
        #2;
        check("flush_idle", 64'(pout().valid), 64'd0);
        next_cycle();
        #2;
        check("flush_no_regrant", 64'({rdy_mask(), pout().valid}), 64'h1E);

        // Counter saturation and reset in the middle of a walk.
        do_reset();
        sel = 1'b0;
        drive(4'h1, 1'b1, 1'b0, 1'b0);
`ifdef PTW_ARB_PERF_EN
        for (int k = 0; k < 20; k++) begin
            wait_grant($sformatf("perf_grant%0d", k), 0);
            respond($sformatf("perf_resp%0d", k), 4'h1);
        end
        check("perf_grant_sat", 64'(rr_gcnt[0]), 64'd15);
        check("perf_grant_ch1", 64'(rr_gcnt[1]), 64'd0);
`endif
        wait_grant("rst_grant_ch0", 0);
        next_cycle(); drive(4'h0, 1'b1, 1'b0, 1'b0);
        #2;
        check("rst_in_wait", 64'(pout().valid), 64'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #2;
        check("rst_ptw_o", 64'(pout()), 64'd0);
        check("rst_ready", 64'(rdy_mask()), 64'hF);
`ifdef PTW_ARB_PERF_EN
        check("rst_perf_grant", 64'(rr_gcnt[0]), 64'd0);
        check("rst_perf_wait", 64'(rr_wcnt), 64'd0);
`endif
        ptw_i.resp.valid = 1'b1;
        #1;
        check("rst_no_resp", 64'(rsp_mask()), 64'h0);
        ptw_i.resp.valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
